pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline. Drives enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles three events: load-use hazards detected in ID, taken branches resolved in MEM, and multi-cycle data-memory accesses via a req/ready handshake.
- Includes a memory-wait watchdog and saturating performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM encoding and the
// control vectors applied to the PC and pipeline registers.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic pc_sel_branch;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_bubble;
  } ctrl_t;

  // Field order: pc_en, pc_sel, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_bubble
  localparam ctrl_t CTRL_NORMAL  = 9'b1_0_1_0_1_0_1_0_0;
  localparam ctrl_t CTRL_FREEZE  = 9'b0_0_0_0_0_0_0_0_1;
  localparam ctrl_t CTRL_TAKEN   = 9'b1_1_1_1_1_1_1_1_0;
  localparam ctrl_t CTRL_LOADUSE = 9'b0_0_0_0_1_1_1_0_0;
  localparam ctrl_t CTRL_ERR     = 9'b0_0_0_0_0_0_0_0_1;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle. The datapath side is the
// master; the hazard controller is the slave.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W_DEF
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic                  idex_mem_r;
  logic [REG_ADDR_W-1:0] idex_wb_addr;
  logic                  exmem_mem_r;
  logic                  exmem_mem_w;
  logic                  exmem_branch;
  logic                  exmem_zero;
  // Handshake: dmem_req is held while an access sits in EX/MEM; the access
  // completes in the cycle where dmem_req && dmem_ready, and not before.
  logic                  dmem_ready;
  logic                  dmem_req;
  logic                  pc_en;
  logic                  pc_sel_branch;
  logic                  ifid_en;
  logic                  ifid_flush;
  logic                  idex_en;
  logic                  idex_flush;
  logic                  exmem_en;
  logic                  exmem_flush;
  logic                  memwb_bubble;

  modport master (
    output id_rs, id_rt, id_uses_rt, idex_mem_r, idex_wb_addr,
           exmem_mem_r, exmem_mem_w, exmem_branch, exmem_zero, dmem_ready,
    input  dmem_req, pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en,
           idex_flush, exmem_en, exmem_flush, memwb_bubble
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, idex_mem_r, idex_wb_addr,
           exmem_mem_r, exmem_mem_w, exmem_branch, exmem_zero, dmem_ready,
    output dmem_req, pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en,
           idex_flush, exmem_en, exmem_flush, memwb_bubble
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for performance counts.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch
// flushes, data-memory wait freeze and a watchdog that parks in ERR.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  pipe_hazard_ctrl_if.slave    bus,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_cycles,
  output logic [1:0]           state_dbg
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

  state_e            state_d, state_q;
  logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q;
  logic              mem_err_d, mem_err_q;
  logic              access, in_err, freeze, taken, loaduse, rs_hit, rt_hit;
  ctrl_t             ctrl;

  assign in_err  = (state_q == ST_ERR);
  assign access  = bus.exmem_mem_r | bus.exmem_mem_w;
  assign bus.dmem_req = access & ~in_err;
  assign freeze  = bus.dmem_req & ~bus.dmem_ready;
  assign taken   = bus.exmem_branch & bus.exmem_zero & ~freeze & ~in_err;
  assign rs_hit  = (bus.idex_wb_addr == bus.id_rs);
  assign rt_hit  = bus.id_uses_rt & (bus.idex_wb_addr == bus.id_rt);
  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign loaduse = bus.idex_mem_r & (bus.idex_wb_addr != REG_ADDR_W'(0)) &
                   (rs_hit | rt_hit) & ~freeze & ~taken & ~in_err;

  always_comb begin
    ctrl = CTRL_NORMAL;
    if (in_err)       ctrl = CTRL_ERR;
    else if (freeze)  ctrl = CTRL_FREEZE;
    else if (taken)   ctrl = CTRL_TAKEN;
    else if (loaduse) ctrl = CTRL_LOADUSE;
  end

  assign bus.pc_en         = ctrl.pc_en;
  assign bus.pc_sel_branch = ctrl.pc_sel_branch;
  assign bus.ifid_en       = ctrl.ifid_en;
  assign bus.ifid_flush    = ctrl.ifid_flush;
  assign bus.idex_en       = ctrl.idex_en;
  assign bus.idex_flush    = ctrl.idex_flush;
  assign bus.exmem_en      = ctrl.exmem_en;
  assign bus.exmem_flush   = ctrl.exmem_flush;
  assign bus.memwb_bubble  = ctrl.memwb_bubble;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!access || bus.dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d   = ST_ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign state_dbg = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (freeze | loaduse),
    .clear (1'b0),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (taken),
    .clear (1'b0),
    .count (flush_cycles)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, rt gating, branch flush,
// memory freeze, priority, counter saturation and watchdog.
module tb_pipe_hazard_ctrl;
  localparam int RW = 5;
  localparam int CW = 4;

  // Control vector order: pc_en, pc_sel, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_bubble
  localparam logic [8:0] E_NORMAL  = 9'b101010100;
  localparam logic [8:0] E_FREEZE  = 9'b000000001;
  localparam logic [8:0] E_TAKEN   = 9'b111111110;
  localparam logic [8:0] E_LOADUSE = 9'b000011100;
  localparam logic [8:0] E_ERR     = 9'b000000001;

  logic          clk;
  logic          rstn;
  logic          mem_err;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_cycles;
  logic [1:0]    state_dbg;
  int            checks;
  int            failures;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(RW)) bus ();

  pipe_hazard_ctrl #(
    .REG_ADDR_W (RW),
    .MEM_TIMEOUT(4),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus.slave),
    .mem_err     (mem_err),
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ctl();
    return {bus.pc_en, bus.pc_sel_branch, bus.ifid_en, bus.ifid_flush, bus.idex_en,
            bus.idex_flush, bus.exmem_en, bus.exmem_flush, bus.memwb_bubble};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
    bus.idex_mem_r = 1'b0; bus.idex_wb_addr = '0;
    bus.exmem_mem_r = 1'b0; bus.exmem_mem_w = 1'b0;
    bus.exmem_branch = 1'b0; bus.exmem_zero = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    settle();
    checks++; if (ctl() !== E_NORMAL) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), E_NORMAL); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL reset_mem_err got=%b exp=0", mem_err); end
    checks++; if (stall_cycles !== 4'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
    checks++; if (flush_cycles !== 4'd0) begin failures++; $display("FAIL reset_flush got=%0d exp=0", flush_cycles); end
    checks++; if (bus.dmem_req !== 1'b0) begin failures++; $display("FAIL reset_dmem_req got=%b exp=0", bus.dmem_req); end
    tick();
  endtask

  task automatic test_loaduse();
    bus.idex_mem_r = 1'b1; bus.idex_wb_addr = 5'd5; bus.id_rs = 5'd5;
    settle();
    checks++; if (ctl() !== E_LOADUSE) begin failures++; $display("FAIL lu_ctl got=%b exp=%b", ctl(), E_LOADUSE); end
    tick();
    idle();
    settle();
    checks++; if (ctl() !== E_NORMAL) begin failures++; $display("FAIL lu_after_ctl got=%b exp=%b", ctl(), E_NORMAL); end
    checks++; if (stall_cycles !== 4'd1) begin failures++; $display("FAIL lu_stall got=%0d exp=1", stall_cycles); end
    bus.idex_mem_r = 1'b1; bus.idex_wb_addr = 5'd0; bus.id_rs = 5'd0;
    settle();
    checks++; if (ctl() !== E_NORMAL) begin failures++; $display("FAIL lu_r0_ctl got=%b exp=%b", ctl(), E_NORMAL); end
    tick();
    idle();
    checks++; if (stall_cycles !== 4'd1) begin failures++; $display("FAIL lu_r0_stall got=%0d exp=1", stall_cycles); end
  endtask

  task automatic test_rt_gating();
    bus.idex_mem_r = 1'b1; bus.idex_wb_addr = 5'd7; bus.id_rt = 5'd7; bus.id_rs = 5'd3;
    bus.id_uses_rt = 1'b0;
    settle();
    checks++; if (ctl() !== E_NORMAL) begin failures++; $display("FAIL rt_off_ctl got=%b exp=%b", ctl(), E_NORMAL); end
    tick();
    checks++; if (stall_cycles !== 4'd1) begin failures++; $display("FAIL rt_off_stall got=%0d exp=1", stall_cycles); end
    bus.id_uses_rt = 1'b1;
    settle();
    checks++; if (ctl() !== E_LOADUSE) begin failures++; $display("FAIL rt_on_ctl got=%b exp=%b", ctl(), E_LOADUSE); end
    tick();
    idle();
    checks++; if (stall_cycles !== 4'd2) begin failures++; $display("FAIL rt_on_stall got=%0d exp=2", stall_cycles); end
  endtask

  task automatic test_branch();
    bus.exmem_branch = 1'b1; bus.exmem_zero = 1'b1;
    settle();
    checks++; if (ctl() !== E_TAKEN) begin failures++; $display("FAIL br_taken_ctl got=%b exp=%b", ctl(), E_TAKEN); end
    tick();
    idle();
    settle();
    checks++; if (ctl() !== E_NORMAL) begin failures++; $display("FAIL br_after_ctl got=%b exp=%b", ctl(), E_NORMAL); end
    checks++; if (flush_cycles !== 4'd1) begin failures++; $display("FAIL br_flush got=%0d exp=1", flush_cycles); end
    bus.exmem_branch = 1'b1; bus.exmem_zero = 1'b0;
    settle();
    checks++; if (ctl() !== E_NORMAL) begin failures++; $display("FAIL br_nt_ctl got=%b exp=%b", ctl(), E_NORMAL); end
    tick();
    idle();
    checks++; if (flush_cycles !== 4'd1) begin failures++; $display("FAIL br_nt_flush got=%0d exp=1", flush_cycles); end
    checks++; if (stall_cycles !== 4'd2) begin failures++; $display("FAIL br_stall got=%0d exp=2", stall_cycles); end
  endtask

  task automatic test_mem_wait();
    logic [1:0] exp_st;
    bus.exmem_mem_r = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_st = (i == 0) ? 2'd0 : 2'd1;
      settle();
      checks++; if (ctl() !== E_FREEZE) begin failures++; $display("FAIL mw_ctl[%0d] got=%b exp=%b", i, ctl(), E_FREEZE); end
      checks++; if (bus.dmem_req !== 1'b1) begin failures++; $display("FAIL mw_req[%0d] got=%b exp=1", i, bus.dmem_req); end
      checks++; if (state_dbg !== exp_st) begin failures++; $display("FAIL mw_state[%0d] got=%0d exp=%0d", i, state_dbg, exp_st); end
      tick();
    end
    bus.dmem_ready = 1'b1;
    settle();
    checks++; if (ctl() !== E_NORMAL) begin failures++; $display("FAIL mw_ready_ctl got=%b exp=%b", ctl(), E_NORMAL); end
    tick();
    idle();
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL mw_done_state got=%0d exp=0", state_dbg); end
    checks++; if (stall_cycles !== 4'd5) begin failures++; $display("FAIL mw_stall got=%0d exp=5", stall_cycles); end
    // Store completing in its first cycle: no stall, no state change.
    bus.exmem_mem_w = 1'b1; bus.dmem_ready = 1'b1;
    settle();
    checks++; if (ctl() !== E_NORMAL) begin failures++; $display("FAIL mw_fast_ctl got=%b exp=%b", ctl(), E_NORMAL); end
    tick();
    idle();
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL mw_fast_state got=%0d exp=0", state_dbg); end
    checks++; if (stall_cycles !== 4'd5) begin failures++; $display("FAIL mw_fast_stall got=%0d exp=5", stall_cycles); end
  endtask

  task automatic test_priority();
    bus.exmem_mem_r = 1'b1; bus.dmem_ready = 1'b0;
    bus.exmem_branch = 1'b1; bus.exmem_zero = 1'b1;
    bus.idex_mem_r = 1'b1; bus.idex_wb_addr = 5'd4; bus.id_rs = 5'd4;
    settle();
    checks++; if (ctl() !== E_FREEZE) begin failures++; $display("FAIL pri_freeze_ctl got=%b exp=%b", ctl(), E_FREEZE); end
    tick();
    checks++; if (state_dbg !== 2'd1) begin failures++; $display("FAIL pri_state got=%0d exp=1", state_dbg); end
    bus.dmem_ready = 1'b1;
    settle();
    checks++; if (ctl() !== E_TAKEN) begin failures++; $display("FAIL pri_taken_ctl got=%b exp=%b", ctl(), E_TAKEN); end
    tick();
    idle();
    checks++; if (flush_cycles !== 4'd2) begin failures++; $display("FAIL pri_flush got=%0d exp=2", flush_cycles); end
    checks++; if (stall_cycles !== 4'd6) begin failures++; $display("FAIL pri_stall got=%0d exp=6", stall_cycles); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL pri_end_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_saturation();
    bus.idex_mem_r = 1'b1; bus.idex_wb_addr = 5'd9; bus.id_rs = 5'd9;
    for (int i = 0; i < 9; i++) tick();
    checks++; if (stall_cycles !== 4'd15) begin failures++; $display("FAIL sat_reach got=%0d exp=15", stall_cycles); end
    for (int i = 0; i < 3; i++) tick();
    idle();
    checks++; if (stall_cycles !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", stall_cycles); end
    checks++; if (flush_cycles !== 4'd2) begin failures++; $display("FAIL sat_flush got=%0d exp=2", flush_cycles); end
  endtask

  task automatic test_watchdog();
    logic [1:0] exp_st;
    bus.exmem_mem_r = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_st = (i == 0) ? 2'd0 : 2'd1;
      settle();
      checks++; if (state_dbg !== exp_st) begin failures++; $display("FAIL wd_state[%0d] got=%0d exp=%0d", i, state_dbg, exp_st); end
      checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL wd_early_err[%0d] got=%b exp=0", i, mem_err); end
      tick();
    end
    checks++; if (state_dbg !== 2'd2) begin failures++; $display("FAIL wd_err_state got=%0d exp=2", state_dbg); end
    checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL wd_mem_err got=%b exp=1", mem_err); end
    checks++; if (bus.dmem_req !== 1'b0) begin failures++; $display("FAIL wd_req got=%b exp=0", bus.dmem_req); end
    checks++; if (ctl() !== E_ERR) begin failures++; $display("FAIL wd_ctl got=%b exp=%b", ctl(), E_ERR); end
    bus.dmem_ready = 1'b1; bus.exmem_branch = 1'b1; bus.exmem_zero = 1'b1;
    bus.idex_mem_r = 1'b1; bus.idex_wb_addr = 5'd2; bus.id_rs = 5'd2;
    settle();
    checks++; if (ctl() !== E_ERR) begin failures++; $display("FAIL wd_hold_ctl got=%b exp=%b", ctl(), E_ERR); end
    tick(); tick();
    checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL wd_sticky got=%b exp=1", mem_err); end
    checks++; if (state_dbg !== 2'd2) begin failures++; $display("FAIL wd_hold_state got=%0d exp=2", state_dbg); end
    checks++; if (flush_cycles !== 4'd2) begin failures++; $display("FAIL wd_flush got=%0d exp=2", flush_cycles); end
    idle();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    settle();
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL wd_rst_err got=%b exp=0", mem_err); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL wd_rst_state got=%0d exp=0", state_dbg); end
    checks++; if (stall_cycles !== 4'd0) begin failures++; $display("FAIL wd_rst_stall got=%0d exp=0", stall_cycles); end
    checks++; if (flush_cycles !== 4'd0) begin failures++; $display("FAIL wd_rst_flush got=%0d exp=0", flush_cycles); end
    checks++; if (ctl() !== E_NORMAL) begin failures++; $display("FAIL wd_rst_ctl got=%b exp=%b", ctl(), E_NORMAL); end
  endtask

  task automatic test_back_to_back();
    bus.idex_mem_r = 1'b1; bus.idex_wb_addr = 5'd12; bus.id_rs = 5'd12;
    settle();
    checks++; if (ctl() !== E_LOADUSE) begin failures++; $display("FAIL b2b_lu_ctl got=%b exp=%b", ctl(), E_LOADUSE); end
    tick();
    idle();
    bus.exmem_branch = 1'b1; bus.exmem_zero = 1'b1;
    settle();
    checks++; if (ctl() !== E_TAKEN) begin failures++; $display("FAIL b2b_br_ctl got=%b exp=%b", ctl(), E_TAKEN); end
    tick();
    idle();
    checks++; if (stall_cycles !== 4'd1) begin failures++; $display("FAIL b2b_stall got=%0d exp=1", stall_cycles); end
    checks++; if (flush_cycles !== 4'd1) begin failures++; $display("FAIL b2b_flush got=%0d exp=1", flush_cycles); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    idle();
    test_reset();
    test_loaduse();
    test_rt_gating();
    test_branch();
    test_mem_wait();
    test_priority();
    test_saturation();
    test_watchdog();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
